// File: rtl/bird_wall_collide.sv
// rtl/bird_wall_collide.sv - frame tick, bird/wall/floor collision check, BCD score and IDLE/RUN/HIT game FSM
// Optional macro NO_WALL_COLLIDE_EN: only the floor can cause a hit.
module bird_wall_collide #(
  parameter int TICK_DIV  = 833333,
  parameter int BIRD_X    = 20,
  parameter int BIRD_SIZE = 4,
  parameter int WALL_W    = 8,
  parameter int GAP_H     = 40,
  parameter int FLOOR_Y   = 116
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic [6:0] bird_y,
  input  logic [7:0] wall_x,
  input  logic [6:0] gap_y,
  output logic       flag,
  output logic       collision,
  output logic       playing,
  output logic [7:0] score
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [8:0] BX_LO   = 9'(BIRD_X);
  localparam logic [8:0] BX_HI   = 9'(BIRD_X + BIRD_SIZE - 1);
  localparam logic [8:0] FLOOR   = 9'(FLOOR_Y);

  typedef enum logic [1:0] {IDLE, RUN, HIT} state_t;
  state_t state, state_nxt;

  logic [CW-1:0] cnt;
  logic          wrap;
  logic [6:0]    snap_bird_y;
  logic [7:0]    snap_wall_x;
  logic [6:0]    snap_gap_y;
  logic          snap_valid;
  logic          hit_r, pass_r, eval_valid, passed;

  logic [8:0] wall_l, wall_r, bird_t, bird_b, gap_t, gap_b;
  logic       hov, outside_gap, floor_hit, wall_hit, hit, pass;

  assign wrap = (cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      flag <= 1'b0;
    end else begin
      cnt  <= wrap ? '0 : cnt + CW'(1);
      flag <= wrap;
    end
  end

  // Snapshot is loaded on the edge that raises flag, so it is valid during the flag cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_bird_y <= '0;
      snap_wall_x <= '0;
      snap_gap_y  <= '0;
      snap_valid  <= 1'b0;
    end else begin
      snap_valid <= wrap && (state == RUN);
      if (wrap && (state == RUN)) begin
        snap_bird_y <= bird_y;
        snap_wall_x <= wall_x;
        snap_gap_y  <= gap_y;
      end
    end
  end

  always_comb begin
    wall_l      = {1'b0, snap_wall_x};
    wall_r      = {1'b0, snap_wall_x} + 9'(WALL_W - 1);
    bird_t      = {2'b00, snap_bird_y};
    bird_b      = {2'b00, snap_bird_y} + 9'(BIRD_SIZE - 1);
    gap_t       = {2'b00, snap_gap_y};
    gap_b       = {2'b00, snap_gap_y} + 9'(GAP_H - 1);
    hov         = (wall_l <= BX_HI) && (wall_r >= BX_LO);
    outside_gap = (bird_t < gap_t) || (bird_b > gap_b);
    floor_hit   = (bird_b >= FLOOR);
    pass        = (wall_r < BX_LO) && !passed;
  end

`ifdef NO_WALL_COLLIDE_EN
  assign wall_hit = 1'b0 & hov & outside_gap;
`else
  assign wall_hit = hov & outside_gap;
`endif

  assign hit = wall_hit | floor_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_r      <= 1'b0;
      pass_r     <= 1'b0;
      eval_valid <= 1'b0;
      passed     <= 1'b1;
    end else begin
      eval_valid <= snap_valid;
      if (snap_valid) begin
        hit_r  <= hit;
        pass_r <= pass;
        // A wall at or right of the bird re-arms scoring for the next crossing.
        if (pass)
          passed <= 1'b1;
        else if (wall_l >= BX_LO)
          passed <= 1'b0;
      end
    end
  end

  function automatic logic [7:0] bcd_inc(input logic [7:0] s);
    if (s == 8'h99)
      return s;
    else if (s[3:0] == 4'd9)
      return {s[7:4] + 4'd1, 4'd0};
    else
      return {s[7:4], s[3:0] + 4'd1};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      collision <= 1'b0;
      score     <= 8'h00;
    end else if (eval_valid && (state == RUN)) begin
      if (hit_r)
        collision <= 1'b1;
      else if (pass_r)
        score <= bcd_inc(score);
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!go) state_nxt = RUN;
      RUN:     if (eval_valid && hit_r) state_nxt = HIT;
      HIT:     state_nxt = HIT;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    playing = (state == RUN);
  end

endmodule

// File: tb/tb_bird_wall_collide.sv
// tb/tb_bird_wall_collide.sv - directed self-checking bench for bird_wall_collide with TICK_DIV=4
module tb_bird_wall_collide;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       go = 1'b1;
  logic [6:0] bird_y = 7'd50;
  logic [7:0] wall_x = 8'd100;
  logic [6:0] gap_y = 7'd40;
  logic       flag, collision, playing;
  logic [7:0] score;

  int checks = 0;
  int failures = 0;

  bird_wall_collide #(.TICK_DIV(4)) dut (
    .clk(clk), .reset(reset), .go(go), .bird_y(bird_y), .wall_x(wall_x),
    .gap_y(gap_y), .flag(flag), .collision(collision), .playing(playing), .score(score)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b1;
    go = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic start_game();
    @(negedge clk);
    go = 1'b0;
    @(negedge clk);
    go = 1'b1;
    check("playing_after_go", playing, 1);
  endtask

  // Advances at least one cycle, stops on the negedge of the next flag cycle.
  task automatic wait_flag();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!flag && n < 20);
    if (!flag) check("flag_timeout", 0, 1);
  endtask

  // Present inputs, let them be captured, then land where that evaluation's result is visible.
  task automatic do_frame(input logic [7:0] wx, input logic [6:0] by);
    wall_x = wx;
    bird_y = by;
    wait_flag();
    repeat (2) @(negedge clk);
  endtask

  task automatic pass_once();
    do_frame(8'd30, 7'd50);
    do_frame(8'd10, 7'd50);
  endtask

  logic [7:0] seq_wx [6] = '{8'd30, 8'd24, 8'd10, 8'd150, 8'd30, 8'd10};
  logic [7:0] seq_sc [6] = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h02};

  initial begin
    reset_dut();
    check("reset_flag", flag, 0);
    check("reset_collision", collision, 0);
    check("reset_playing", playing, 0);
    check("reset_score", score, 8'h00);

    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      check($sformatf("idle_flag_%0d", i), flag, (i % 4 == 0) ? 1 : 0);
    end
    check("idle_playing", playing, 0);
    check("idle_collision", collision, 0);
    check("idle_score", score, 8'h00);

    start_game();
    for (int i = 0; i < 10; i++) do_frame(8'd100, 7'd50);
    check("run_playing", playing, 1);
    check("run_collision", collision, 0);
    check("run_score", score, 8'h00);

    for (int i = 0; i < 6; i++) begin
      do_frame(seq_wx[i], 7'd50);
      check($sformatf("seq_score_%0d", i), score, seq_sc[i]);
    end
    for (int i = 0; i < 7; i++) pass_once();
    check("score_09", score, 8'h09);
    pass_once();
    check("score_10", score, 8'h10);
    for (int i = 0; i < 39; i++) pass_once();
    check("score_49", score, 8'h49);
    pass_once();
    check("score_50", score, 8'h50);
    for (int i = 0; i < 49; i++) pass_once();
    check("score_99", score, 8'h99);
    pass_once();
    check("score_sat", score, 8'h99);
    check("score_run_playing", playing, 1);

    reset_dut();
    start_game();
    do_frame(8'd22, 7'd50);
    check("in_gap_collision", collision, 0);
    check("in_gap_playing", playing, 1);
    bird_y = 7'd10;
    wait_flag();
    check("hit_f0", collision, 0);
    @(negedge clk);
    check("hit_f1", collision, 0);
    @(negedge clk);
    check("hit_f2", collision, 1);
    check("hit_playing", playing, 0);
    repeat (20) @(negedge clk);
    check("hit_sticky", collision, 1);
    check("hit_score", score, 8'h00);
    go = 1'b0;
    repeat (8) @(negedge clk);
    go = 1'b1;
    check("hit_go_ignored", playing, 0);

    reset_dut();
    start_game();
    gap_y = 7'd40;
    do_frame(8'd100, 7'd113);
    check("floor_collision", collision, 1);
    check("floor_playing", playing, 0);

    reset_dut();
    start_game();
    wall_x = 8'd22;
    bird_y = 7'd10;
    wait_flag();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_flag", flag, 0);
    check("rst_collision", collision, 0);
    check("rst_playing", playing, 0);
    check("rst_score", score, 8'h00);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("rst_no_stale", collision, 0);
    check("rst_idle", playing, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bird_wall_collide.md
Name: bird_wall_collide

Overview:
- Upstream stage of the game controller. Generates the per-frame `flag` tick and the `collision` signal that the bird and wall state machines consume.
- Once per frame, checks the bird box against the current wall column and the screen floor.
- Keeps a 2-digit BCD score of walls passed.
- Runs an IDLE/RUN/HIT game FSM gated by the active-low `go` key.

Parameters:
- TICK_DIV, 833333: clk cycles per frame tick (50 MHz / 60 Hz); minimum 4.
- BIRD_X, 20: fixed left x of bird.
- BIRD_SIZE, 4: bird width and height in pixels.
- WALL_W, 8: wall column width.
- GAP_H, 40: vertical opening height.
- FLOOR_Y, 116: first y row counted as floor.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- go  in  1  key, active-low (0 = pressed)
- bird_y  in  7  bird top y
- wall_x  in  8  wall left x (0..159)
- gap_y  in  7  top y of wall opening
- flag  out  1  frame tick, one-cycle pulse
- collision  out  1  sticky hit indicator
- playing  out  1  high in RUN
- score  out  8  BCD, [7:4] tens, [3:0] units

Behaviour:
- Reset values:
  - All outputs 0; FSM in IDLE.
  - Tick counter 0; snapshot registers 0; `passed` flag 1.
  - Reset mid-frame discards any in-flight evaluation.
- Tick counter:
  - Counts 0..TICK_DIV-1 in every state.
  - `flag` = 1 for exactly the one cycle after the counter wraps from TICK_DIV-1 to 0.
  - The first pulse occurs TICK_DIV cycles after reset release.
- FSM transitions:
  - IDLE -> RUN on any cycle with go==0.
  - RUN -> HIT the cycle after an evaluation reports a hit.
  - HIT holds until reset.
  - `playing` = (state==RUN).
- Evaluation pipeline (RUN only):
  - Cycle F, where `flag`=1: capture bird_y, wall_x, gap_y into snapshot registers.
  - Cycle F+1: compute the comparisons from the snapshot and register `hit` and `pass`.
  - Cycle F+2: update `collision`, `score` and the state.
  - Flags arriving in IDLE or HIT are ignored.
- Arithmetic: all comparisons use 9-bit zero-extended operands, so there is no wrap.
  - Horizontal overlap (hov): wall_x <= BIRD_X+BIRD_SIZE-1 AND wall_x+WALL_W-1 >= BIRD_X.
  - Outside gap: bird_y < gap_y OR bird_y+BIRD_SIZE-1 > gap_y+GAP_H-1.
  - Floor: bird_y+BIRD_SIZE-1 >= FLOOR_Y.
  - hit = (hov AND outside gap) OR floor.
- Pass detection:
  - pass = (wall_x+WALL_W-1 < BIRD_X) AND `passed`==0.
  - On pass: `passed` <= 1.
  - When a snapshot has wall_x >= BIRD_X: `passed` <= 0. This re-arms after the wall wraps to the right edge.
- Score:
  - BCD increment, units roll 9->0 with tens carry.
  - Saturates at 0x99.
  - Frozen in HIT and IDLE.
- Collision:
  - Set to 1 at F+2 on hit; stays 1 until reset.
  - hit and pass in the same evaluation: hit wins, score unchanged, `passed` still updates.
- go is ignored outside IDLE.

Optional Feature:
- Macro: NO_WALL_COLLIDE_EN.
- Defined: the hov/gap term is forced to 0, so only the floor causes a hit. Scoring is unaffected (debug / demo mode).
- Undefined: full hit equation as above.

Test Plan (TICK_DIV=4, other parameters at default):
- Reset then hold go=1 for 40 cycles -> flag pulses every 4 cycles; playing=0; score=0x00; collision=0.
- go=0 for 1 cycle; bird_y=50, gap_y=40, wall_x=100 for 10 frames -> playing=1; collision=0; score=0x00.
- In RUN, bird_y=50, gap_y=40, wall_x=22 presented at the flag -> no hit (inside gap). Then bird_y=10 -> collision=1 exactly 2 cycles after that flag, playing=0, and collision stays 1 for 20 further cycles.
- In RUN, wall_x sequence 30,24,10,150,30,10 on successive flags with bird inside the gap -> score goes 0x00 -> 0x01 -> 0x02, one increment per pass, no double count.
- Preload 99 passes in RUN -> score=0x99; a further pass keeps 0x99. Check the BCD carries at 0x09->0x10 and 0x49->0x50.
- bird_y=113 (bottom row 116) in RUN -> collision=1, with or without NO_WALL_COLLIDE_EN. Assert reset one cycle after a flag -> all outputs 0 the next cycle and no stale collision.
